// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    localparam int INST_BYTES = 4;

    typedef logic [31:0] addr_t;

    function automatic addr_t next_pc(input addr_t pc);
        return pc + addr_t'(INST_BYTES);
    endfunction

    // Redirect targets may arrive unaligned; the low bits are simply dropped.
    function automatic addr_t align_pc(input addr_t pc);
        return pc & ~addr_t'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/ifetch_inst_fifo.sv
// Prefetch queue: synchronous FIFO with a registered head word.
// Flush wins over push and pop; head reads zero after reset or flush.
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign rd_next = rd_ptr + 1'b1;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head register tracks the entry at rd_ptr so the consumer sees a flop output.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + ONE_CNT;
                2'b01:   cnt <= cnt - ONE_CNT;
                default: cnt <= cnt;
            endcase
            if (do_pop && (cnt > ONE_CNT)) begin
                head <= mem[rd_next];
            end else if (do_push && (empty || (do_pop && (cnt == ONE_CNT)))) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch controller: issues PC-ordered word reads over req/ack,
// buffers them in a prefetch queue and hands them to the control unit.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inst_consume_i,
    output logic [31:0] inst_o,
    output logic        inst_ready_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        inhibit_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    fetch_state_t state;
    addr_t        pc;
    logic         consume_q;
    logic         pop;
    logic         push;
    logic         fifo_empty;
    logic         fifo_full;

    // A word is retired on the falling edge of the consume level.
    assign pop          = consume_q & ~inst_consume_i & inst_ready_o;
    assign push         = (state == WAIT) && mem_ack_i && !redirect_i;
    assign inst_ready_o = !fifo_empty;

    inst_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (32)
    ) u_inst_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push      (push),
        .push_data (mem_data_i),
        .pop       (pop),
        .flush     (redirect_i),
        .head      (inst_o),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            consume_q <= 1'b0;
        end else begin
            consume_q <= inst_consume_i;
        end
    end

    // Requests are only issued from IDLE, so the queue never holds more than
    // one in-flight word beyond its count and a push can never overflow.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_i) begin
                        pc <= align_pc(redirect_pc_i);
                    end else if (!inhibit_i && !fifo_full) begin
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pc;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IDLE;
                        pc        <= redirect_i ? align_pc(redirect_pc_i) : next_pc(pc);
                    end else if (redirect_i) begin
                        pc    <= align_pc(redirect_pc_i);
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (redirect_i) begin
                        pc <= align_pc(redirect_pc_i);
                    end
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the fetch queue and PC.
module tb_ifetch;

    localparam int QDEPTH = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        inst_consume_i;
    logic [31:0] inst_o;
    logic        inst_ready_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inhibit_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_inst;
    logic        w_ready;
    logic        w_ack;

    always #5 clk_i = ~clk_i;

    ifetch #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .inst_consume_i (inst_consume_i),
        .inst_o         (inst_o),
        .inst_ready_o   (inst_ready_o),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .inhibit_i      (inhibit_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ack_i      (mem_ack_i),
        .mem_data_i     (mem_data_i)
    );

    // Second instance near the top of the address space to exercise PC wrap.
    assign w_ack = w_req;

    ifetch #(
        .RESET_PC (32'hFFFF_FFF8),
        .QDEPTH   (QDEPTH)
    ) dut_wrap (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .inst_consume_i (1'b0),
        .inst_o         (w_inst),
        .inst_ready_o   (w_ready),
        .redirect_i     (1'b0),
        .redirect_pc_i  (32'h0),
        .inhibit_i      (1'b0),
        .mem_req_o      (w_req),
        .mem_addr_o     (w_addr),
        .mem_ack_i      (w_ack),
        .mem_data_i     (32'h0000_00A5)
    );

    logic [31:0] wrap_addrs[$];
    logic        w_req_d = 1'b0;

    always @(negedge clk_i) begin
        if (reset_i === 1'b1) begin
            wrap_addrs.delete();
        end else if (w_req === 1'b1 && w_req_d === 1'b0) begin
            wrap_addrs.push_back(w_addr);
        end
        w_req_d = w_req;
    end

    int          tests    = 0;
    int          failures = 0;

    // Reference model state: buffered words in order, next fetch PC, and
    // whether the outstanding request has been orphaned by a redirect.
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    bit          m_stale;
    bit          m_cq;
    int          ack_delay;
    int          mem_wait;
    logic [31:0] data_ctr;
    int          issue_count;
    logic [31:0] last_issue_addr;

    bit          s_consume;
    bit          s_redirect;
    bit          s_inhibit;
    logic [31:0] s_rpc;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic failTimeout(input string tag);
        tests++;
        failures++;
        $error("[TB] FAIL %s: timeout waiting for DUT event", tag);
    endtask

    // One clock cycle: drive inputs at the falling edge, advance the model,
    // then check every output at the next falling edge.
    task automatic applyStimulus();
        bit          pre_req;
        bit          ack;
        bit          do_pop;
        bit          exp_req;
        logic [31:0] pre_addr;
        int          qsz;

        pre_req  = (mem_req_o === 1'b1);
        pre_addr = mem_addr_o;
        ack      = !reset_i && pre_req && (mem_wait >= ack_delay);

        inst_consume_i = s_consume;
        redirect_i     = s_redirect;
        redirect_pc_i  = s_rpc;
        inhibit_i      = s_inhibit;
        mem_ack_i      = ack;
        mem_data_i     = data_ctr;

        qsz = m_q.size();
        if (reset_i) begin
            m_q.delete();
            m_pc     = 32'h0000_0000;
            m_stale  = 1'b0;
            m_cq     = 1'b0;
            mem_wait = 0;
            exp_req  = 1'b0;
        end else begin
            do_pop  = m_cq && !s_consume && (qsz > 0);
            exp_req = pre_req ? !ack : (!s_inhibit && !s_redirect && (qsz < QDEPTH));
            if (s_redirect) begin
                m_q.delete();
                m_pc    = s_rpc & ~32'h3;
                m_stale = pre_req && !ack;
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (ack) begin
                    if (m_stale) begin
                        m_stale = 1'b0;
                    end else begin
                        m_q.push_back(data_ctr);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            m_cq = s_consume;
            if (ack) begin
                data_ctr = data_ctr + 32'd1;
                mem_wait = 0;
            end else if (pre_req) begin
                mem_wait++;
            end else begin
                mem_wait = 0;
            end
        end

        @(posedge clk_i);
        @(negedge clk_i);

        checkOutput("mem_req", 32'(mem_req_o), 32'(exp_req));
        if (mem_req_o === 1'b1) begin
            if (!pre_req) begin
                checkOutput("issue_addr", mem_addr_o, m_pc);
                issue_count++;
                last_issue_addr = mem_addr_o;
            end else begin
                checkOutput("hold_addr", mem_addr_o, pre_addr);
            end
        end
        checkOutput("ready", 32'(inst_ready_o), 32'(m_q.size() > 0));
        if (m_q.size() > 0) checkOutput("inst", inst_o, m_q[0]);
    endtask

    initial begin
        int base;
        int n;

        reset_i        = 1'b1;
        inst_consume_i = 1'b0;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        inhibit_i      = 1'b0;
        mem_ack_i      = 1'b0;
        mem_data_i     = 32'h0;
        s_consume      = 1'b0;
        s_redirect     = 1'b0;
        s_inhibit      = 1'b0;
        s_rpc          = 32'h0;
        ack_delay      = 1;
        mem_wait       = 0;
        data_ctr       = 32'h0000_0001;
        issue_count    = 0;
        last_issue_addr = 32'h0;
        m_pc           = 32'h0;
        m_stale        = 1'b0;
        m_cq           = 1'b0;

        @(negedge clk_i);
        applyStimulus();
        applyStimulus();
        checkOutput("rst_inst", inst_o, 32'h0);
        checkOutput("rst_addr", mem_addr_o, 32'h0);
        checkOutput("rst_req", 32'(mem_req_o), 32'h0);
        reset_i = 1'b0;

        // Fill the queue with no consumer activity.
        for (int i = 0; i < 14; i++) applyStimulus();
        checkOutput("fill_ready", 32'(inst_ready_o), 32'h1);
        checkOutput("fill_inst", inst_o, 32'h1);
        checkOutput("fill_noreq", 32'(mem_req_o), 32'h0);
        checkOutput("fill_issues", 32'(issue_count), 32'd4);
        checkOutput("fill_last_addr", last_issue_addr, 32'h0000_000C);

        // Retire three words, then hold consume high without popping.
        for (int i = 0; i < 3; i++) begin
            s_consume = 1'b1;
            applyStimulus();
            s_consume = 1'b0;
            applyStimulus();
        end
        s_consume = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("hold_no_pop", inst_o, 32'h4);
        s_consume = 1'b0;
        applyStimulus();

        // Redirect while a slow request is outstanding.
        ack_delay = 3;
        n = 0;
        while (mem_req_o !== 1'b1 && n < 20) begin
            applyStimulus();
            n++;
        end
        if (mem_req_o !== 1'b1) failTimeout("redir_wait_req");
        s_redirect = 1'b1;
        s_rpc      = 32'h0000_0103;
        applyStimulus();
        s_redirect = 1'b0;
        checkOutput("redir_ready", 32'(inst_ready_o), 32'h0);
        checkOutput("redir_req_held", 32'(mem_req_o), 32'h1);
        base = issue_count;
        n = 0;
        while (issue_count == base && n < 20) begin
            applyStimulus();
            n++;
        end
        if (issue_count == base) failTimeout("redir_next_issue");
        else checkOutput("redir_addr", last_issue_addr, 32'h0000_0100);

        // Redirect in the same cycle as an ack and a pop.
        ack_delay = 1;
        s_consume = 1'b1;
        n = 0;
        while (!(mem_req_o === 1'b1 && mem_wait >= ack_delay && m_q.size() > 0 && m_cq) && n < 30) begin
            applyStimulus();
            n++;
        end
        if (n >= 30) failTimeout("ackredir_setup");
        s_consume  = 1'b0;
        s_redirect = 1'b1;
        s_rpc      = 32'h0000_0200;
        applyStimulus();
        s_redirect = 1'b0;
        checkOutput("ackredir_ready", 32'(inst_ready_o), 32'h0);
        checkOutput("ackredir_req", 32'(mem_req_o), 32'h0);
        base = issue_count;
        n = 0;
        while (issue_count == base && n < 20) begin
            applyStimulus();
            n++;
        end
        if (issue_count == base) failTimeout("ackredir_next_issue");
        else checkOutput("ackredir_addr", last_issue_addr, 32'h0000_0200);

        // Inhibit mid-request: the request completes, no new ones, queue drains.
        for (int i = 0; i < 6; i++) applyStimulus();
        n = 0;
        while (mem_req_o !== 1'b1 && n < 20) begin
            s_consume = ~s_consume;
            applyStimulus();
            n++;
        end
        if (mem_req_o !== 1'b1) failTimeout("inhibit_wait_req");
        s_inhibit = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_consume = (i % 2 == 0);
            applyStimulus();
        end
        checkOutput("inhibit_noreq", 32'(mem_req_o), 32'h0);
        checkOutput("inhibit_drained", 32'(inst_ready_o), 32'h0);
        s_inhibit = 1'b0;
        s_consume = 1'b0;

        checkOutput("wrap_count", 32'(wrap_addrs.size() >= 3), 32'h1);
        checkOutput("wrap_addr0", (wrap_addrs.size() > 0) ? wrap_addrs[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        checkOutput("wrap_addr1", (wrap_addrs.size() > 1) ? wrap_addrs[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        checkOutput("wrap_addr2", (wrap_addrs.size() > 2) ? wrap_addrs[2] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            s_consume  = 1'($urandom_range(0, 1));
            s_redirect = ($urandom_range(0, 19) == 0);
            s_rpc      = $urandom;
            s_inhibit  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) ack_delay = $urandom_range(0, 3);
            applyStimulus();
        end
        s_redirect = 1'b0;
        s_inhibit  = 1'b0;

        // Reset in the middle of a request abandons it.
        ack_delay = 3;
        n = 0;
        while (mem_req_o !== 1'b1 && n < 20) begin
            applyStimulus();
            n++;
        end
        if (mem_req_o !== 1'b1) failTimeout("reset_wait_req");
        reset_i = 1'b1;
        applyStimulus();
        reset_i = 1'b0;
        checkOutput("midreset_req", 32'(mem_req_o), 32'h0);
        checkOutput("midreset_ready", 32'(inst_ready_o), 32'h0);
        checkOutput("midreset_inst", inst_o, 32'h0);
        applyStimulus();
        checkOutput("midreset_addr", mem_addr_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
